// File: rtl/pdp11_operand_fetch_if.sv
// Register-file and memory-bus signals of the PDP-11 operand-fetch sequencer.
// The master side is the sequencer; the slave side is the register file plus memory.
interface pdp11_operand_fetch_if;
  logic [2:0]  rf_sela;
  logic [15:0] rf_a;
  logic [2:0]  rf_selb;
  logic        rf_we;
  logic [15:0] rf_w;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [15:0] mem_rdata;

  modport master (
    output rf_sela, rf_selb, rf_we, rf_w, mem_req, mem_addr,
    input  rf_a, mem_ack, mem_rdata
  );

  modport slave (
    input  rf_sela, rf_selb, rf_we, rf_w, mem_req, mem_addr,
    output rf_a, mem_ack, mem_rdata
  );
endinterface

// File: rtl/pdp11_operand_fetch.sv
// PDP-11 operand-fetch sequencer: decodes one (mode, register) specifier into an effective
// address and operand. Define OPFETCH_ODD_TRAP_EN to trap odd word addresses with err.
module pdp11_operand_fetch (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [5:0]  spec,
  input  logic        byte_op,
  input  logic        nofetch,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        is_reg,
  output logic [15:0] addr,
  output logic [15:0] operand,
  pdp11_operand_fetch_if.master bus
);

`ifdef OPFETCH_ODD_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, INDEX, REG, PTR, DATA, DONE} state_t;

  state_t      state, state_n;
  logic [2:0]  mode_q, rsel_q;
  logic        byte_q, nofetch_q, is_reg_q, err_q;
  logic [15:0] x_q, addr_q, operand_q;

  logic [2:0]  sela, selb;
  logic        we, req, trap;
  logic [15:0] wdata, maddr, ea, step;
  logic        ptr_mode;

  // Deferred modes 3/5 always move by a full word because the register holds a pointer.
  assign step     = (byte_q && rsel_q < 3'd6 && !mode_q[0]) ? 16'd1 : 16'd2;
  assign ptr_mode = mode_q[0] && (mode_q != 3'd1);

  always_comb begin
    state_n = state;
    sela    = 3'd0;
    selb    = 3'd0;
    we      = 1'b0;
    wdata   = 16'd0;
    req     = 1'b0;
    maddr   = 16'd0;
    ea      = 16'd0;
    trap    = 1'b0;
    case (state)
      IDLE: if (start) state_n = (spec[5:4] == 2'b11) ? INDEX : REG;
      INDEX: begin
        sela = 3'd7;
        if (TRAP_EN && bus.rf_a[0]) begin
          trap    = 1'b1;
          state_n = DONE;
        end else begin
          req   = 1'b1;
          maddr = bus.rf_a;
          if (bus.mem_ack) begin
            we      = 1'b1;
            selb    = 3'd7;
            wdata   = bus.rf_a + 16'd2;
            state_n = REG;
          end
        end
      end
      REG: begin
        sela = rsel_q;
        case (mode_q)
          3'd0: ea = 16'd0;
          3'd1: ea = bus.rf_a;
          3'd2, 3'd3: begin
            ea    = bus.rf_a;
            we    = 1'b1;
            selb  = rsel_q;
            wdata = bus.rf_a + step;
          end
          3'd4, 3'd5: begin
            ea    = bus.rf_a - step;
            we    = 1'b1;
            selb  = rsel_q;
            wdata = bus.rf_a - step;
          end
          default: ea = bus.rf_a + x_q;
        endcase
        if (mode_q == 3'd0)  state_n = DONE;
        else if (ptr_mode)   state_n = PTR;
        else if (nofetch_q)  state_n = DONE;
        else                 state_n = DATA;
      end
      PTR: begin
        if (TRAP_EN && addr_q[0]) begin
          trap    = 1'b1;
          state_n = DONE;
        end else begin
          req   = 1'b1;
          maddr = addr_q;
          if (bus.mem_ack) state_n = nofetch_q ? DONE : DATA;
        end
      end
      DATA: begin
        if (TRAP_EN && addr_q[0] && !byte_q) begin
          trap    = 1'b1;
          state_n = DONE;
        end else begin
          req   = 1'b1;
          maddr = addr_q;
          if (bus.mem_ack) state_n = DONE;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      mode_q    <= 3'd0;
      rsel_q    <= 3'd0;
      byte_q    <= 1'b0;
      nofetch_q <= 1'b0;
      is_reg_q  <= 1'b0;
      err_q     <= 1'b0;
      x_q       <= 16'd0;
      addr_q    <= 16'd0;
      operand_q <= 16'd0;
    end else begin
      state <= state_n;
      case (state)
        IDLE: if (start) begin
          mode_q    <= spec[5:3];
          rsel_q    <= spec[2:0];
          byte_q    <= byte_op;
          nofetch_q <= nofetch;
          is_reg_q  <= 1'b0;
          err_q     <= 1'b0;
          x_q       <= 16'd0;
          addr_q    <= 16'd0;
          operand_q <= 16'd0;
        end
        INDEX: if (req && bus.mem_ack) x_q <= bus.mem_rdata;
        REG: begin
          addr_q <= ea;
          if (mode_q == 3'd0) begin
            is_reg_q  <= 1'b1;
            operand_q <= byte_q ? {8'd0, bus.rf_a[7:0]} : bus.rf_a;
          end
        end
        PTR: if (req && bus.mem_ack) addr_q <= bus.mem_rdata;
        DATA: if (req && bus.mem_ack) begin
          if (!byte_q)       operand_q <= bus.mem_rdata;
          else if (addr_q[0]) operand_q <= {8'd0, bus.mem_rdata[15:8]};
          else               operand_q <= {8'd0, bus.mem_rdata[7:0]};
        end
        default: ;
      endcase
      if (trap) begin
        err_q     <= 1'b1;
        operand_q <= 16'd0;
      end
    end
  end

  // Memory is word-organised, so bit 0 never reaches the bus.
  assign bus.mem_req  = req;
  assign bus.mem_addr = {maddr[15:1], 1'b0};
  assign bus.rf_sela  = sela;
  assign bus.rf_selb  = selb;
  assign bus.rf_we    = we;
  assign bus.rf_w     = wdata;

  assign busy    = (state != IDLE);
  assign done    = (state == DONE);
  assign err     = TRAP_EN ? err_q : 1'b0;
  assign is_reg  = is_reg_q;
  assign addr    = addr_q;
  assign operand = operand_q;

endmodule

// File: tb/tb_pdp11_operand_fetch.sv
// Bench for pdp11_operand_fetch: register-file and memory models, expected results
// queued at stimulus time and compared when done pulses.
module tb_pdp11_operand_fetch;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, start, byte_op, nofetch;
  logic [5:0]  spec;
  logic        busy, done, err, is_reg;
  logic [15:0] addr, operand;

  pdp11_operand_fetch_if bus ();

  pdp11_operand_fetch dut (
    .clk(clk), .reset(reset), .start(start), .spec(spec), .byte_op(byte_op),
    .nofetch(nofetch), .busy(busy), .done(done), .err(err), .is_reg(is_reg),
    .addr(addr), .operand(operand), .bus(bus)
  );

  logic [15:0] rf [8];
  logic [15:0] mem [32768];
  logic        poke_en;
  logic [2:0]  poke_sel;
  logic [15:0] poke_val;
  int          ws = 0, wcnt = 0, cyc = 0, reqc = 0, wec = 0, stab_err = 0;
  logic [15:0] last_maddr = 16'd0, prev_addr = 16'd0;
  logic        prev_hold = 1'b0;
  int          errors = 0, checks = 0;

  typedef struct {
    logic [15:0] addr, operand;
    logic        is_reg, err;
    int          lat, reqs, wrs;
  } exp_t;
  exp_t sbq[$];

  assign bus.rf_a      = rf[bus.rf_sela];
  assign bus.mem_rdata = mem[bus.mem_addr[15:1]];
  assign bus.mem_ack   = bus.mem_req && (wcnt == ws);

  always @(posedge clk) begin
    if (bus.rf_we) rf[bus.rf_selb] <= bus.rf_w;
    else if (poke_en) rf[poke_sel] <= poke_val;
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.mem_req) reqc <= reqc + 1;
    if (bus.rf_we) wec <= wec + 1;
    if (bus.mem_req && bus.mem_ack) last_maddr <= bus.mem_addr;
    wcnt <= (bus.mem_req && !bus.mem_ack) ? wcnt + 1 : 0;
    if (prev_hold && bus.mem_req && bus.mem_addr != prev_addr) stab_err <= stab_err + 1;
    prev_hold <= bus.mem_req && !bus.mem_ack;
    prev_addr <= bus.mem_addr;
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic poke(input logic [2:0] r, input logic [15:0] v);
    @(negedge clk);
    poke_en = 1'b1; poke_sel = r; poke_val = v;
    @(negedge clk);
    poke_en = 1'b0;
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] v);
    mem[a[15:1]] = v;
  endtask

  task automatic run_op(input string tag, input logic [5:0] s, input logic b, input logic nf,
                        input int w, input logic [15:0] e_addr, input logic [15:0] e_opnd,
                        input logic e_isreg, input logic e_err, input int e_lat,
                        input int e_reqs, input int e_wrs, input bit hold);
    exp_t e;
    int   t0, r0, w0;
    bit   got;
    e.addr = e_addr; e.operand = e_opnd; e.is_reg = e_isreg; e.err = e_err;
    e.lat = e_lat; e.reqs = e_reqs; e.wrs = e_wrs;
    sbq.push_back(e);
    ws = w;
    @(negedge clk);
    spec = s; byte_op = b; nofetch = nf; start = 1'b1;
    r0 = reqc; w0 = wec;
    @(posedge clk);
    #1;
    t0 = cyc;
    if (hold) begin
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1;
        break;
      end
    end
    e = sbq.pop_front();
    if (!got) begin
      check({tag, "_timeout"}, 16'd0, 16'd1);
      return;
    end
    check({tag, "_addr"}, addr, e.addr);
    check({tag, "_operand"}, operand, e.operand);
    check({tag, "_isreg"}, 16'(is_reg), 16'(e.is_reg));
    check({tag, "_err"}, 16'(err), 16'(e.err));
    check({tag, "_busy"}, 16'(busy), 16'd1);
    check({tag, "_latency"}, 16'(cyc - t0 + 1), 16'(e.lat));
    check({tag, "_reqcycles"}, 16'(reqc - r0), 16'(e.reqs));
    check({tag, "_rfwrites"}, 16'(wec - w0), 16'(e.wrs));
    @(negedge clk);
    check({tag, "_donepulse"}, 16'(done), 16'd0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; spec = 6'd0; byte_op = 1'b0; nofetch = 1'b0;
    poke_en = 1'b0; poke_sel = 3'd0; poke_val = 16'd0;
    wr(16'o1000, 16'o7777); wr(16'o2000, 16'o3000); wr(16'o3000, 16'o55);
    wr(16'o100, 16'o10);    wr(16'o112, 16'o3000);  wr(16'o4000, 16'o1111);
    wr(16'hFFFE, 16'hAB53); wr(16'o200, 16'o2);     wr(16'o1236, 16'o600);
    repeat (3) @(negedge clk);
    check("rst_ctrl", {10'd0, busy, done, err, is_reg, bus.rf_we, bus.mem_req}, 16'd0);
    check("rst_addr", addr, 16'd0);
    check("rst_operand", operand, 16'd0);
    check("rst_memaddr", bus.mem_addr, 16'd0);
    check("rst_rfw", bus.rf_w, 16'd0);
    check("rst_sel", {10'd0, bus.rf_sela, bus.rf_selb}, 16'd0);
    reset = 1'b0;
    poke(0, 16'hFFFF); poke(1, 16'o1000); poke(2, 16'o2002); poke(3, 16'o1234);
    poke(4, 16'o1001); poke(5, 16'h0000); poke(6, 16'o4000); poke(7, 16'o100);

    run_op("m0", 6'o03, 0, 0, 0, 16'd0, 16'o1234, 1, 0, 2, 0, 0, 0);
    check("m0_r3", rf[3], 16'o1234);
    run_op("m2w", 6'o21, 0, 0, 0, 16'o1000, 16'o7777, 0, 0, 3, 1, 1, 1);
    check("m2w_r1", rf[1], 16'o1002);
    poke(1, 16'o1000);
    run_op("m2b", 6'o21, 1, 0, 0, 16'o1000, 16'o377, 0, 0, 3, 1, 1, 0);
    check("m2b_r1", rf[1], 16'o1001);
    run_op("m2b_sp", 6'o26, 1, 0, 0, 16'o4000, 16'o111, 0, 0, 3, 1, 1, 0);
    check("m2b_sp_r6", rf[6], 16'o4002);
    run_op("m5", 6'o52, 0, 0, 0, 16'o3000, 16'o55, 0, 0, 4, 2, 1, 0);
    check("m5_r2", rf[2], 16'o2000);
    poke(2, 16'o2002);
    run_op("m5b", 6'o52, 1, 0, 0, 16'o3000, 16'o55, 0, 0, 4, 2, 1, 0);
    check("m5b_r2", rf[2], 16'o2000);
    run_op("m6pc", 6'o67, 0, 0, 0, 16'o112, 16'o3000, 0, 0, 4, 2, 1, 0);
    check("m6pc_pc", rf[7], 16'o102);
    poke(7, 16'o100);
    run_op("m6pc_ws3", 6'o67, 0, 0, 3, 16'o112, 16'o3000, 0, 0, 10, 8, 1, 0);
    check("m6pc_ws3_pc", rf[7], 16'o102);
`ifdef OPFETCH_ODD_TRAP_EN
    run_op("m1odd", 6'o14, 0, 0, 0, 16'o1001, 16'd0, 0, 1, 3, 0, 0, 0);
`else
    run_op("m1odd", 6'o14, 0, 0, 0, 16'o1001, 16'o7777, 0, 0, 3, 1, 0, 0);
    check("m1odd_memaddr", last_maddr, 16'o1000);
`endif
    run_op("m4wrap", 6'o45, 0, 0, 0, 16'hFFFE, 16'hAB53, 0, 0, 3, 1, 1, 0);
    check("m4wrap_r5", rf[5], 16'hFFFE);
    run_op("m2bwrap", 6'o20, 1, 0, 0, 16'hFFFF, 16'h00AB, 0, 0, 3, 1, 1, 0);
    check("m2bwrap_r0", rf[0], 16'h0000);
    poke(1, 16'o2000);
    run_op("m3nf", 6'o31, 0, 1, 0, 16'o3000, 16'd0, 0, 0, 3, 1, 1, 0);
    check("m3nf_r1", rf[1], 16'o2002);
    poke(7, 16'o100);
    run_op("m7", 6'o77, 0, 0, 0, 16'o3000, 16'o55, 0, 0, 5, 3, 1, 0);
    check("m7_pc", rf[7], 16'o102);
    poke(7, 16'o200);
    run_op("m6r3", 6'o63, 0, 0, 0, 16'o1236, 16'o600, 0, 0, 4, 2, 1, 0);
    check("m6r3_pc", rf[7], 16'o202);

    // Reset while mode 3 waits on its pointer read.
    poke(1, 16'o2000);
    ws = 6;
    @(negedge clk);
    spec = 6'o31; byte_op = 1'b0; nofetch = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    check("rstmid_req_before", 16'(bus.mem_req), 16'd1);
    reset = 1'b1;
    @(negedge clk);
    check("rstmid_req", 16'(bus.mem_req), 16'd0);
    check("rstmid_busy", 16'(busy), 16'd0);
    check("rstmid_done", 16'(done), 16'd0);
    reset = 1'b0;
    check("rstmid_r1", rf[1], 16'o2002);
    poke(1, 16'o1000);
    run_op("after_rst", 6'o21, 0, 0, 0, 16'o1000, 16'o7777, 0, 0, 3, 1, 1, 0);
    check("after_rst_r1", rf[1], 16'o1002);

    check("addr_stable", 16'(stab_err), 16'd0);
    check("sb_empty", 16'(sbq.size()), 16'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
